// File: rtl/clk_div_bank.sv
// clk_div_bank: APB-configured bank of glitch-free integer clock dividers, shadow/active config per channel.
// Optional per-channel output-period counters are built when CLK_DIV_BANK_PERIOD_COUNT_EN is defined.
module clk_div_bank #(
    parameter int   NUM_CHANNELS    = 3,
    parameter int   DIV_WIDTH       = 8,
    parameter int   DEFAULT_DIV     = 2,
    parameter logic ENABLE_IN_RESET = 1'b1,
    parameter int   APB_ADDR_WIDTH  = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic [NUM_CHANNELS-1:0]   clk_o,
    output logic [NUM_CHANNELS-1:0]   pending_o
);
    localparam int IDX_W = APB_ADDR_WIDTH - 2;
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_TWO = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [IDX_W-1:0]     STATUS_IDX = IDX_W'(NUM_CHANNELS);

    logic                          access;
    logic                          wr_access;
    logic [IDX_W-1:0]              idx;
    logic [NUM_CHANNELS-1:0][31:0] cfg_word;
`ifdef CLK_DIV_BANK_PERIOD_COUNT_EN
    logic [NUM_CHANNELS-1:0][31:0] period_word;
`endif
    logic                          unused_bits;

    assign access      = psel_i & penable_i;
    assign wr_access   = access & pwrite_i;
    assign idx         = paddr_i[APB_ADDR_WIDTH-1:2];
    assign pready_o    = 1'b1;
    assign unused_bits = ^{paddr_i[1:0], pwdata_i[30:DIV_WIDTH]};

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        logic [DIV_WIDTH-1:0] shadow_div_reg;
        logic [DIV_WIDTH-1:0] act_div_reg;
        logic [DIV_WIDTH-1:0] cnt_reg;
        logic [DIV_WIDTH-1:0] eff_div;
        logic                 shadow_en_reg;
        logic                 act_en_reg;
        logic                 pending_reg;
        logic                 clk_reg;
        logic                 cfg_we;
        logic                 wrap;
        logic                 apply;

        assign cfg_we  = wr_access && (idx == IDX_W'(gi));
        // DIV below 2 is stored as written but runs the divider at 2.
        assign eff_div = (act_div_reg < DIV_TWO) ? DIV_TWO : act_div_reg;
        assign wrap    = act_en_reg && (cnt_reg == eff_div - DIV_ONE);
        // A disabled channel has a constant-low output, so it can take new settings at once.
        assign apply   = pending_reg && (wrap || !act_en_reg);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                shadow_div_reg <= DIV_RST;
                shadow_en_reg  <= ENABLE_IN_RESET;
                act_div_reg    <= DIV_RST;
                act_en_reg     <= ENABLE_IN_RESET;
                pending_reg    <= 1'b0;
                cnt_reg        <= '0;
                clk_reg        <= 1'b0;
            end else begin
                if (cfg_we) begin
                    shadow_div_reg <= pwdata_i[DIV_WIDTH-1:0];
                    shadow_en_reg  <= pwdata_i[31];
                end
                pending_reg <= cfg_we || (pending_reg && !apply);
                if (apply) begin
                    act_div_reg <= shadow_div_reg;
                    act_en_reg  <= shadow_en_reg;
                end
                clk_reg <= act_en_reg && (cnt_reg < (eff_div >> 1));
                if (!act_en_reg || wrap) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + DIV_ONE;
                end
            end
        end

`ifdef CLK_DIV_BANK_PERIOD_COUNT_EN
        logic [31:0] periods_reg;
        logic        cnt_clr;

        assign cnt_clr = wr_access && (idx == IDX_W'(NUM_CHANNELS + 1 + gi));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                periods_reg <= '0;
            end else if (cnt_clr) begin
                periods_reg <= '0;
            end else if (wrap) begin
                periods_reg <= periods_reg + 32'd1;
            end
        end

        assign period_word[gi] = periods_reg;
`endif

        assign clk_o[gi]     = clk_reg;
        assign pending_o[gi] = pending_reg;
        assign cfg_word[gi]  = {shadow_en_reg, {(31-DIV_WIDTH){1'b0}}, shadow_div_reg};
    end

    always_comb begin
        prdata_o  = '0;
        pslverr_o = 1'b0;
        if (access) begin
            pslverr_o = 1'b1;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (idx == IDX_W'(i)) begin
                    pslverr_o = 1'b0;
                    if (!pwrite_i) prdata_o = cfg_word[i];
                end
            end
            if (idx == STATUS_IDX) begin
                pslverr_o = pwrite_i;
                if (!pwrite_i) prdata_o = 32'(pending_o);
            end
`ifdef CLK_DIV_BANK_PERIOD_COUNT_EN
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (idx == IDX_W'(NUM_CHANNELS + 1 + i)) begin
                    pslverr_o = 1'b0;
                    if (!pwrite_i) prdata_o = period_word[i];
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: register-map vector table, directed corner sequences,
// and randomized APB traffic against a waveform-queue reference model.
module tb_clk_div_bank;
    localparam int NCH = 3;
    localparam int DW  = 8;
    localparam int AW  = 12;

    logic            clk_i     = 1'b0;
    logic            rst_ni    = 1'b0;
    logic [AW-1:0]   paddr_i   = '0;
    logic            psel_i    = 1'b0;
    logic            penable_i = 1'b0;
    logic            pwrite_i  = 1'b0;
    logic [31:0]     pwdata_i  = '0;
    logic [31:0]     prdata_o;
    logic            pready_o;
    logic            pslverr_o;
    logic [NCH-1:0]  clk_o;
    logic [NCH-1:0]  pending_o;

    clk_div_bank #(
        .NUM_CHANNELS   (NCH),
        .DIV_WIDTH      (DW),
        .DEFAULT_DIV    (2),
        .ENABLE_IN_RESET(1'b1),
        .APB_ADDR_WIDTH (AW)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .paddr_i  (paddr_i),
        .psel_i   (psel_i),
        .penable_i(penable_i),
        .pwrite_i (pwrite_i),
        .pwdata_i (pwdata_i),
        .prdata_o (prdata_o),
        .pready_o (pready_o),
        .pslverr_o(pslverr_o),
        .clk_o    (clk_o),
        .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: each channel keeps a queue holding the rest of its current output period.
    logic [DW-1:0] m_sh_div  [NCH];
    logic          m_sh_en   [NCH];
    logic          m_pend    [NCH];
    logic [DW-1:0] m_cur_div [NCH];
    logic          m_cur_en  [NCH];
    bit            m_wave    [NCH][$];
    logic          m_clk     [NCH];
    logic [31:0]   m_periods [NCH];

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_fill(input int ch);
        int e;
        e = (m_cur_div[ch] < 2) ? 2 : int'(m_cur_div[ch]);
        if (m_cur_en[ch]) begin
            repeat (e / 2) m_wave[ch].push_back(1'b1);
            repeat (e - e / 2) m_wave[ch].push_back(1'b0);
        end else begin
            m_wave[ch].push_back(1'b0);
        end
    endtask

    task automatic m_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_sh_div[ch]  = 8'd2;
            m_sh_en[ch]   = 1'b1;
            m_pend[ch]    = 1'b0;
            m_cur_div[ch] = 8'd2;
            m_cur_en[ch]  = 1'b1;
            m_clk[ch]     = 1'b0;
            m_periods[ch] = 32'd0;
            m_wave[ch].delete();
            m_fill(ch);
        end
    endtask

    task automatic m_step();
        int   idx;
        logic wr;
        idx = int'(paddr_i[AW-1:2]);
        wr  = psel_i && penable_i && pwrite_i;
        for (int ch = 0; ch < NCH; ch++) begin
            m_clk[ch] = m_wave[ch].pop_front();
            if (m_wave[ch].size() == 0) begin
                if (m_cur_en[ch]) m_periods[ch] = m_periods[ch] + 32'd1;
                if (m_pend[ch]) begin
                    m_cur_div[ch] = m_sh_div[ch];
                    m_cur_en[ch]  = m_sh_en[ch];
                    m_pend[ch]    = 1'b0;
                end
                m_fill(ch);
            end
        end
        if (wr) begin
            if (idx < NCH) begin
                m_sh_div[idx] = pwdata_i[DW-1:0];
                m_sh_en[idx]  = pwdata_i[31];
                m_pend[idx]   = 1'b1;
            end
`ifdef CLK_DIV_BANK_PERIOD_COUNT_EN
            else if (idx > NCH && idx <= 2 * NCH) begin
                m_periods[idx-NCH-1] = 32'd0;
            end
`endif
        end
    endtask

    function automatic logic [NCH-1:0] m_clk_vec();
        logic [NCH-1:0] v;
        for (int ch = 0; ch < NCH; ch++) v[ch] = m_clk[ch];
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_pend_vec();
        logic [NCH-1:0] v;
        for (int ch = 0; ch < NCH; ch++) v[ch] = m_pend[ch];
        return v;
    endfunction

    task automatic exp_apb(input logic wr, input logic [AW-1:0] addr,
                           output logic err, output logic [31:0] data);
        int idx;
        idx  = int'(addr[AW-1:2]);
        err  = 1'b1;
        data = '0;
        if (idx < NCH) begin
            err = 1'b0;
            if (!wr) data = {m_sh_en[idx], 23'b0, m_sh_div[idx]};
        end else if (idx == NCH) begin
            err = wr;
            if (!wr) data = 32'(m_pend_vec());
        end
`ifdef CLK_DIV_BANK_PERIOD_COUNT_EN
        else if (idx <= 2 * NCH) begin
            err = 1'b0;
            if (!wr) data = m_periods[idx-NCH-1];
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (!rst_ni) m_reset();
        else m_step();
        #1;
        chk("clk_o", 32'(clk_o), 32'(m_clk_vec()));
        chk("pending_o", 32'(pending_o), 32'(m_pend_vec()));
    endtask

    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err);
        logic        e_err;
        logic [31:0] e_data;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = wr;
        paddr_i   = addr;
        pwdata_i  = wd;
        tick();
        penable_i = 1'b1;
        #1;
        exp_apb(wr, addr, e_err, e_data);
        chk("pslverr_o", 32'(pslverr_o), 32'(e_err));
        chk("prdata_o", prdata_o, e_data);
        rd  = prdata_o;
        err = pslverr_o;
        $display("APB %s addr=0x%03h wdata=0x%08h rdata=0x%08h err=%0d", wr ? "WR" : "RD",
                 addr, wd, rd, err);
        tick();
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
    endtask

    task automatic wait_pclr(input int ch, input int max);
        int n;
        n = 0;
        while (pending_o[ch] && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (pending_o[ch]) begin
            errors++;
            $display("FAIL wait_pending ch%0d: got 1 after %0d cycles, expected 0", ch, max);
        end
    endtask

    initial begin
        vec_t        vecs[16];
        logic [31:0] rd;
        logic        er;
        logic [9:0]  got;
        logic [7:0]  lows;
        int          op;
        int          ch;
        logic [31:0] d;

        vecs[0]  = '{1'b0, 12'h000, 32'h0,         1'b0, 32'h8000_0002};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,         1'b0, 32'h8000_0002};
        vecs[2]  = '{1'b0, 12'h008, 32'h0,         1'b0, 32'h8000_0002};
        vecs[3]  = '{1'b0, 12'h00C, 32'h0,         1'b0, 32'h0};
        vecs[4]  = '{1'b0, 12'h020, 32'h0,         1'b1, 32'h0};
        vecs[5]  = '{1'b1, 12'h00C, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 12'h00C, 32'h0,         1'b0, 32'h0};
`ifdef CLK_DIV_BANK_PERIOD_COUNT_EN
        vecs[7]  = '{1'b0, 12'h01C, 32'h0,         1'b1, 32'h0};
`else
        vecs[7]  = '{1'b0, 12'h010, 32'h0,         1'b1, 32'h0};
`endif
        vecs[8]  = '{1'b0, 12'hFFC, 32'h0,         1'b1, 32'h0};
        vecs[9]  = '{1'b1, 12'h020, 32'h1234_5678, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 12'h000, 32'h0,         1'b0, 32'h8000_0002};
        vecs[11] = '{1'b1, 12'h004, 32'h1234_5601, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 12'h004, 32'h0,         1'b0, 32'h0000_0001};
        vecs[13] = '{1'b1, 12'h004, 32'h8000_0003, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 12'h004, 32'h0,         1'b0, 32'h8000_0003};
        vecs[15] = '{1'b0, 12'h006, 32'h0,         1'b0, 32'h8000_0003};

        // Reset, then every channel rises on the first edge with period 2.
        rst_ni = 1'b0;
        repeat (3) tick();
        chk("reset_clk_o", 32'(clk_o), 32'h0);
        rst_ni = 1'b1;
        tick();
        chk("first_edge_clk_o", 32'(clk_o), 32'h7);
        tick();
        chk("second_edge_clk_o", 32'(clk_o), 32'h0);
        tick();
        chk("third_edge_clk_o", 32'(clk_o), 32'h7);

        foreach (vecs[i]) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("tbl%0d_rdata", i), rd, vecs[i].exp_rdata);
        end
        wait_pclr(1, 20);

        // DIV 2 -> 5 written during a high phase of channel 0.
        for (int n = 0; n < 4 && clk_o[0] != 1'b0; n++) tick();
        apb_xfer(1'b1, 12'h000, 32'h8000_0005, rd, er);
        chk("div5_pending", 32'(pending_o[0]), 32'h1);
        wait_pclr(0, 10);
        got = '0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            got = {got[8:0], clk_o[0]};
        end
        chk("div5_wave", 32'(got), 32'(10'b0110001100));

        // Disable mid-period on DIV 8, then re-enable.
        apb_xfer(1'b1, 12'h000, 32'h8000_0008, rd, er);
        wait_pclr(0, 20);
        repeat (3) tick();
        apb_xfer(1'b1, 12'h000, 32'h0000_0008, rd, er);
        wait_pclr(0, 20);
        lows = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            lows[i] = clk_o[0];
        end
        chk("disabled_low", 32'(lows), 32'h0);
        apb_xfer(1'b1, 12'h000, 32'h8000_0008, rd, er);
        chk("reen_pending", 32'(pending_o[0]), 32'h1);
        chk("reen_clk_apply", 32'(clk_o[0]), 32'h0);
        tick();
        chk("reen_pending_clr", 32'(pending_o[0]), 32'h0);
        chk("reen_clk_next", 32'(clk_o[0]), 32'h0);
        tick();
        chk("reen_first_high", 32'(clk_o[0]), 32'h1);

        // Two writes inside one DIV 8 period: only the last applies.
        apb_xfer(1'b1, 12'h000, 32'h8000_0008, rd, er);
        wait_pclr(0, 20);
        apb_xfer(1'b1, 12'h000, 32'h8000_0004, rd, er);
        apb_xfer(1'b1, 12'h000, 32'h8000_0006, rd, er);
        apb_xfer(1'b0, 12'h00C, 32'h0, rd, er);
        chk("status_before", rd, 32'h1);
        wait_pclr(0, 20);
        apb_xfer(1'b0, 12'h00C, 32'h0, rd, er);
        chk("status_after", rd, 32'h0);
        apb_xfer(1'b0, 12'h000, 32'h0, rd, er);
        chk("cfg0_last_write", rd, 32'h8000_0006);

        // Period counter on DIV 4.
        apb_xfer(1'b1, 12'h000, 32'h8000_0004, rd, er);
        wait_pclr(0, 20);
`ifdef CLK_DIV_BANK_PERIOD_COUNT_EN
        apb_xfer(1'b1, 12'h010, 32'h0, rd, er);
        repeat (37) tick();
        apb_xfer(1'b0, 12'h010, 32'h0, rd, er);
        chk("count_40_cycles", rd, 32'd10);
        tick();
        apb_xfer(1'b1, 12'h010, 32'h0, rd, er);
        apb_xfer(1'b0, 12'h010, 32'h0, rd, er);
        chk("count_cleared", rd, 32'd0);
`else
        apb_xfer(1'b0, 12'h010, 32'h0, rd, er);
        chk("count_absent_err", 32'(er), 32'h1);
        chk("count_absent_data", rd, 32'h0);
`endif

        // Randomized APB traffic against the model.
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 9);
            if (op < 5) begin
                ch    = $urandom_range(0, NCH - 1);
                d     = $urandom;
                d[31] = ($urandom_range(0, 4) != 0);
                d[7:0] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
                apb_xfer(1'b1, 12'(ch * 4 + $urandom_range(0, 3)), d, rd, er);
            end else if (op < 8) begin
                apb_xfer(1'b0, 12'($urandom_range(0, 2 * NCH + 6) * 4), 32'h0, rd, er);
            end else begin
                apb_xfer(1'b1, 12'($urandom_range(NCH, 2 * NCH + 6) * 4), $urandom, rd, er);
            end
            repeat ($urandom_range(0, 12)) tick();
        end

        // Asynchronous reset mid-cycle truncates outputs immediately.
        tick();
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_clk_o", 32'(clk_o), 32'h0);
        chk("async_rst_pending", 32'(pending_o), 32'h0);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        chk("rerelease_clk_o", 32'(clk_o), 32'h7);
        apb_xfer(1'b0, 12'h000, 32'h0, rd, er);
        chk("rerelease_cfg0", rd, 32'h8000_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
